// File: rtl/plen_stats.sv
// Packet-length statistics: live good/bad/byte/min/max accumulators with a
// valid/ready snapshot port that freezes a copy of the live values on request.
module plen_stats #(
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [15:0]   plen_tdata,
  input  logic          plen_tuser,
  input  logic          plen_tvalid,
  input  logic          clear,
  input  logic          snap_req,
  output logic          snap_valid,
  input  logic          snap_ready,
  output logic [CW-1:0] good_count,
  output logic [CW-1:0] bad_count,
  output logic [47:0]   byte_count,
  output logic [15:0]   min_plen,
  output logic [15:0]   max_plen
);

  typedef enum logic [0:0] {
    StIdle,
    StHold
  } state_e;

  localparam logic [15:0] MinReset = 16'hFFFF;
  localparam logic [15:0] MaxReset = 16'h0000;

  // Live accumulators
  logic [CW-1:0] r_good;
  logic [CW-1:0] r_bad;
  logic [47:0]   r_byte;
  logic [15:0]   r_min;
  logic [15:0]   r_max;

  // Snapshot registers driving the outputs directly
  state_e        r_state;
  logic          r_snap_valid;
  logic [CW-1:0] r_snap_good;
  logic [CW-1:0] r_snap_bad;
  logic [47:0]   r_snap_byte;
  logic [15:0]   r_snap_min;
  logic [15:0]   r_snap_max;

  logic          w_is_good;
  logic          w_is_bad;
  logic [48:0]   w_byte_sum;
  logic [CW-1:0] w_good_nx;
  logic [CW-1:0] w_bad_nx;
  logic [47:0]   w_byte_nx;
  logic [15:0]   w_min_nx;
  logic [15:0]   w_max_nx;

  // Zero-length packets count as bad even when not flagged corrupt.
  assign w_is_good  = plen_tvalid & ~plen_tuser & (plen_tdata != 16'd0);
  assign w_is_bad   = plen_tvalid & ~w_is_good;
  assign w_byte_sum = {1'b0, r_byte} + {33'd0, plen_tdata};

  // Live values including this cycle's event; shared by the live update and
  // the snapshot load so a coincident event lands in both.
  always_comb begin
    w_good_nx = r_good;
    w_bad_nx  = r_bad;
    w_byte_nx = r_byte;
    w_min_nx  = r_min;
    w_max_nx  = r_max;
    if (w_is_good) begin
      if (r_good != {CW{1'b1}}) begin
        w_good_nx = r_good + CW'(1);
      end
      w_byte_nx = w_byte_sum[48] ? {48{1'b1}} : w_byte_sum[47:0];
      if (plen_tdata < r_min) begin
        w_min_nx = plen_tdata;
      end
      if (plen_tdata > r_max) begin
        w_max_nx = plen_tdata;
      end
    end
    if (w_is_bad && (r_bad != {CW{1'b1}})) begin
      w_bad_nx = r_bad + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      r_good <= '0;
      r_bad  <= '0;
      r_byte <= '0;
      r_min  <= MinReset;
      r_max  <= MaxReset;
    end else begin
      r_good <= w_good_nx;
      r_bad  <= w_bad_nx;
      r_byte <= w_byte_nx;
      r_min  <= w_min_nx;
      r_max  <= w_max_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state      <= StIdle;
      r_snap_valid <= 1'b0;
      r_snap_good  <= '0;
      r_snap_bad   <= '0;
      r_snap_byte  <= '0;
      r_snap_min   <= MinReset;
      r_snap_max   <= MaxReset;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (snap_req) begin
            r_snap_good  <= w_good_nx;
            r_snap_bad   <= w_bad_nx;
            r_snap_byte  <= w_byte_nx;
            r_snap_min   <= w_min_nx;
            r_snap_max   <= w_max_nx;
            r_snap_valid <= 1'b1;
            r_state      <= StHold;
          end
        end
        StHold: begin
          // snap_req is deliberately not looked at here, even on accept.
          if (snap_ready) begin
            r_snap_valid <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: begin
          r_snap_valid <= 1'b0;
          r_state      <= StIdle;
        end
      endcase
    end
  end

  assign snap_valid = r_snap_valid;
  assign good_count = r_snap_good;
  assign bad_count  = r_snap_bad;
  assign byte_count = r_snap_byte;
  assign min_plen   = r_snap_min;
  assign max_plen   = r_snap_max;

endmodule

// File: tb/tb_plen_stats.sv
// Directed bench for plen_stats: a behavioural model pushes expected snapshots
// on request; they are popped and compared when snap_valid rises.
module tb_plen_stats;

  typedef struct packed {
    logic [31:0] g;
    logic [31:0] b;
    logic [47:0] by;
    logic [15:0] mn;
    logic [15:0] mx;
  } snap_t;

  localparam snap_t SnapReset = '{g: 32'd0, b: 32'd0, by: 48'd0, mn: 16'hFFFF, mx: 16'h0000};

  logic        clk;
  logic        resetn;
  logic [15:0] plen_tdata;
  logic        plen_tuser;
  logic        plen_tvalid;
  logic        clear;
  logic        snap_req;
  logic        snap_ready;

  logic        snap_valid;
  logic [31:0] good_count;
  logic [31:0] bad_count;
  logic [47:0] byte_count;
  logic [15:0] min_plen;
  logic [15:0] max_plen;

  // Narrow-counter instance for saturation, sharing the same stimulus.
  logic        snap_valid2;
  logic [1:0]  good_count2;
  logic [1:0]  bad_count2;
  logic [47:0] byte_count2;
  logic [15:0] min_plen2;
  logic [15:0] max_plen2;

  int    checks = 0;
  int    errors = 0;
  snap_t live;
  snap_t cur;
  logic  m_hold;
  snap_t sb[$];

  plen_stats #(.CW(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .plen_tdata (plen_tdata),
    .plen_tuser (plen_tuser),
    .plen_tvalid(plen_tvalid),
    .clear      (clear),
    .snap_req   (snap_req),
    .snap_valid (snap_valid),
    .snap_ready (snap_ready),
    .good_count (good_count),
    .bad_count  (bad_count),
    .byte_count (byte_count),
    .min_plen   (min_plen),
    .max_plen   (max_plen)
  );

  plen_stats #(.CW(2)) dut2 (
    .clk        (clk),
    .resetn     (resetn),
    .plen_tdata (plen_tdata),
    .plen_tuser (plen_tuser),
    .plen_tvalid(plen_tvalid),
    .clear      (clear),
    .snap_req   (snap_req),
    .snap_valid (snap_valid2),
    .snap_ready (snap_ready),
    .good_count (good_count2),
    .bad_count  (bad_count2),
    .byte_count (byte_count2),
    .min_plen   (min_plen2),
    .max_plen   (max_plen2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  task automatic chk_snap(input string tag, input snap_t e);
    chk({tag, ".good"}, 64'(good_count), 64'(e.g));
    chk({tag, ".bad"},  64'(bad_count),  64'(e.b));
    chk({tag, ".byte"}, 64'(byte_count), 64'(e.by));
    chk({tag, ".min"},  64'(min_plen),   64'(e.mn));
    chk({tag, ".max"},  64'(max_plen),   64'(e.mx));
  endtask

  // One clock of stimulus; model advances alongside and outputs are checked #1 after the edge.
  task automatic cyc(input logic tv, input logic tu, input logic [15:0] td,
                     input logic clr, input logic req, input logic rdy);
    snap_t       nx;
    logic [48:0] s;
    logic        was_valid;
    plen_tvalid = tv;
    plen_tuser  = tu;
    plen_tdata  = td;
    clear       = clr;
    snap_req    = req;
    snap_ready  = rdy;
    nx = live;
    if (tv) begin
      if (!tu && td != 16'd0) begin
        if (nx.g != 32'hFFFF_FFFF) nx.g = nx.g + 32'd1;
        s = {1'b0, nx.by} + {33'd0, td};
        nx.by = s[48] ? 48'hFFFF_FFFF_FFFF : s[47:0];
        if (td < nx.mn) nx.mn = td;
        if (td > nx.mx) nx.mx = td;
      end else if (nx.b != 32'hFFFF_FFFF) begin
        nx.b = nx.b + 32'd1;
      end
    end
    if (!m_hold) begin
      if (req) begin
        sb.push_back(nx);
        m_hold = 1'b1;
      end
    end else if (rdy) begin
      m_hold = 1'b0;
    end
    live = clr ? SnapReset : nx;
    was_valid = snap_valid;
    @(posedge clk);
    #1;
    chk("snap_valid", 64'(snap_valid), 64'(m_hold));
    if (snap_valid && !was_valid) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) cur = sb.pop_front();
    end
    if (snap_valid) chk_snap("snap", cur);
    plen_tvalid = 1'b0;
    clear       = 1'b0;
    snap_req    = 1'b0;
    snap_ready  = 1'b0;
  endtask

  // Reset for one cycle with live-looking stimulus that must be ignored.
  task automatic do_reset();
    resetn      = 1'b0;
    plen_tvalid = 1'b1;
    plen_tuser  = 1'b0;
    plen_tdata  = 16'd77;
    snap_req    = 1'b1;
    clear       = 1'b0;
    snap_ready  = 1'b0;
    @(posedge clk);
    #1;
    live   = SnapReset;
    m_hold = 1'b0;
    sb.delete();
    chk("rst.snap_valid", 64'(snap_valid), 64'd0);
    chk_snap("rst", SnapReset);
    chk("rst.snap_valid2", 64'(snap_valid2), 64'd0);
    resetn      = 1'b1;
    plen_tvalid = 1'b0;
    snap_req    = 1'b0;
  endtask

  initial begin
    resetn      = 1'b0;
    plen_tdata  = 16'd0;
    plen_tuser  = 1'b0;
    plen_tvalid = 1'b0;
    clear       = 1'b0;
    snap_req    = 1'b0;
    snap_ready  = 1'b0;
    live        = SnapReset;
    cur         = SnapReset;
    m_hold      = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // Basic counting
    cyc(1'b1, 1'b0, 16'd64,   1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 16'd1500, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 16'd60,   1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 16'd200,  1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 16'd0,    1'b0, 1'b1, 1'b0);
    chk_snap("basic", '{g: 32'd3, b: 32'd1, by: 48'd1624, mn: 16'd60, mx: 16'd1500});
    cyc(1'b0, 1'b0, 16'd0,    1'b0, 1'b0, 1'b1);

    // Same-cycle event on empty stats
    do_reset();
    cyc(1'b1, 1'b0, 16'd100, 1'b0, 1'b1, 1'b0);
    chk_snap("same_cycle", '{g: 32'd1, b: 32'd0, by: 48'd100, mn: 16'd100, mx: 16'd100});
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

    // Back-pressure: held outputs, ignored second request
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc((i % 2) == 0, 1'b0, 16'd64, 1'b0, i == 5, 1'b0);
    end
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    chk("hold.good_plus5", 64'(good_count), 64'd6);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

    // Read-and-clear, then empty follow-up snapshot
    cyc(1'b1, 1'b0, 16'd80, 1'b1, 1'b1, 1'b0);
    chk_snap("rdclr", '{g: 32'd7, b: 32'd0, by: 48'd500, mn: 16'd64, mx: 16'd100});
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    chk_snap("after_clr", SnapReset);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

    // Clear alone discards the coincident event; clear in HOLD keeps snapshot
    cyc(1'b1, 1'b0, 16'd55, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 16'd33, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 16'd20, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 16'd90, 1'b1, 1'b0, 1'b0);
    chk_snap("clr_in_hold", '{g: 32'd1, b: 32'd0, by: 48'd20, mn: 16'd20, mx: 16'd20});
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    chk("clr_in_hold.live_good", 64'(good_count), 64'd0);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

    // Saturation and runt on the 2-bit counter instance
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 16'd10, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    chk("sat.good2", 64'(good_count2), 64'd3);
    chk("sat.bad2",  64'(bad_count2),  64'd1);
    chk("sat.byte2", 64'(byte_count2), 64'd40);
    chk("sat.good",  64'(good_count),  64'd4);
    chk("sat.bad",   64'(bad_count),   64'd1);
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1);

    // Reset while holding an unaccepted snapshot
    cyc(1'b1, 1'b0, 16'd300, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 16'd0,   1'b0, 1'b0, 1'b0);
    do_reset();
    cyc(1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("post_rst.snap_valid", 64'(snap_valid), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
